// File: rtl/axi3_pkg.sv
// Shared AXI3 types for the slave-side blocks: burst encoding, response codes,
// write-sink FSM states and the per-beat address stepping function.
package axi3_pkg;

  // Widest address the stepping helper handles; callers extend/truncate.
  localparam int unsigned AXI_ADDR_MAX_W = 64;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_RSVD  = 2'd3
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Address of the beat following 'addr'. Carries beyond the caller's address
  // width are dropped when the caller truncates the result.
  function automatic logic [AXI_ADDR_MAX_W-1:0] next_beat_addr(
    input logic [AXI_ADDR_MAX_W-1:0] addr,
    input logic [2:0]                size,
    input logic [7:0]                len,
    input burst_e                    burst
  );
    logic [AXI_ADDR_MAX_W-1:0] nbytes;
    logic [AXI_ADDR_MAX_W-1:0] wrap_m1;
    nbytes  = AXI_ADDR_MAX_W'(1) << size;
    wrap_m1 = (nbytes * (AXI_ADDR_MAX_W'(len) + AXI_ADDR_MAX_W'(1))) - AXI_ADDR_MAX_W'(1);
    case (burst)
      BURST_INCR: next_beat_addr = (addr & ~(nbytes - AXI_ADDR_MAX_W'(1))) + nbytes;
      BURST_WRAP: next_beat_addr = (addr & ~wrap_m1) | ((addr + nbytes) & wrap_m1);
      default:    next_beat_addr = addr;
    endcase
  endfunction

endpackage

// File: rtl/axi3_bytemem.sv
// Byte-enabled RAM: one synchronous write port with per-lane strobes and one
// combinational read port.
//   clk     : write clock
//   we      : write enable (lanes further qualified by wstrb)
//   waddr   : word index to write
//   wstrb   : byte lane enables
//   wdata   : write data
//   raddr   : word index to read
//   rdata_c : word at raddr (combinational)
module axi3_bytemem
  import axi3_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_W-1:0]     rdata_c
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] mem [DEPTH];

  // Lane-masked write; storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/axi3_slave_write_sink.sv
// AXI3 slave write path: accepts one burst at a time, steps FIXED/INCR/WRAP
// addresses, writes beats into a byte-enabled RAM and grades the B response.
//   ACLK, ARESETn         : clock, synchronous active-low reset
//   AW*                   : write address channel (slave side)
//   W*                    : write data channel (slave side)
//   B*                    : write response channel (slave side)
//   dbg_addr / dbg_rdata  : combinational RAM peek by word index
module axi3_slave_write_sink
  import axi3_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned ID_W           = 3,
  parameter int unsigned LEN_W          = 4,
  parameter int unsigned BRST_W         = 3,
  parameter int unsigned MEM_WORDS_LOG2 = 10
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  input  logic                      AWVALID,
  output logic                      AWREADY,
  input  logic [ID_W-1:0]           AWID,
  input  logic [ADDR_W-1:0]         AWADDR,
  input  logic [LEN_W-1:0]          AWLEN,
  input  logic [2:0]                AWSIZE,
  input  logic [BRST_W-1:0]         AWBURST,
  input  logic                      WVALID,
  output logic                      WREADY,
  input  logic [ID_W-1:0]           WID,
  input  logic [DATA_W-1:0]         WDATA,
  input  logic [DATA_W/8-1:0]       WSTRB,
  input  logic                      WLAST,
  output logic                      BVALID,
  input  logic                      BREADY,
  output logic [ID_W-1:0]           BID,
  output logic [1:0]                BRESP,
  input  logic [MEM_WORDS_LOG2-1:0] dbg_addr,
  output logic [DATA_W-1:0]         dbg_rdata
);

  localparam int unsigned STRB_W  = DATA_W / 8;
  localparam int unsigned OFF_W   = $clog2(STRB_W);
  localparam int unsigned WORD_HI = MEM_WORDS_LOG2 + OFF_W;

  state_e              state_q, state_next;
  logic [ID_W-1:0]     id_q, id_next;
  logic [ADDR_W-1:0]   addr_q, addr_next;
  logic [LEN_W-1:0]    len_q, len_next;
  logic [LEN_W-1:0]    beat_q, beat_next;
  logic [2:0]          size_q, size_next;
  burst_e              burst_q, burst_next;
  logic                dec_q, dec_next;
  logic                slv_q, slv_next;
  logic                nowr_q, nowr_next;
  logic [ID_W-1:0]     bid_next;
  logic [1:0]          bresp_next;

  logic                aw_fire, w_fire, b_fire;
  logic                wrap_len_ok, cfg_err, oor, proto_err, last_beat, mem_we;
  logic [ADDR_W-1:0]   aw_bytes_m1;
  burst_e              aw_burst;
  logic                unused_brst;

  assign aw_fire = AWVALID & AWREADY;
  assign w_fire  = WVALID & WREADY;
  assign b_fire  = BVALID & BREADY;

  // Only the two low burst bits carry meaning.
  assign aw_burst    = burst_e'(AWBURST[1:0]);
  assign unused_brst = &{1'b0, AWBURST[BRST_W-1:2]};

  // Burst shapes that are rejected up front and never write.
  assign aw_bytes_m1 = (ADDR_W'(1) << AWSIZE) - ADDR_W'(1);
  assign wrap_len_ok = (AWLEN == LEN_W'(1)) || (AWLEN == LEN_W'(3)) ||
                       (AWLEN == LEN_W'(7)) || (AWLEN == LEN_W'(15));
  assign cfg_err = (aw_burst == BURST_RSVD) || (AWSIZE > 3'(OFF_W)) ||
                   ((aw_burst == BURST_WRAP) &&
                    (!wrap_len_ok || ((AWADDR & aw_bytes_m1) != '0)));

  // Per-beat checks on the current beat.
  assign oor       = (addr_q >> WORD_HI) != '0;
  assign last_beat = WLAST || (beat_q == len_q);
  assign proto_err = (WID != id_q) ||
                     (WLAST && (beat_q != len_q)) ||
                     (!WLAST && (beat_q == len_q));
  assign mem_we    = ARESETn && (state_q == ST_DATA) && w_fire &&
                     !nowr_q && !dec_q && !oor;

  // Next-state and burst context.
  always_comb begin
    state_next = state_q;
    id_next    = id_q;
    addr_next  = addr_q;
    len_next   = len_q;
    beat_next  = beat_q;
    size_next  = size_q;
    burst_next = burst_q;
    dec_next   = dec_q;
    slv_next   = slv_q;
    nowr_next  = nowr_q;
    bid_next   = BID;
    bresp_next = BRESP;
    unique case (state_q)
      ST_IDLE: begin
        if (aw_fire) begin
          state_next = ST_DATA;
          id_next    = AWID;
          addr_next  = AWADDR;
          len_next   = AWLEN;
          size_next  = AWSIZE;
          burst_next = aw_burst;
          beat_next  = '0;
          dec_next   = 1'b0;
          slv_next   = cfg_err;
          nowr_next  = cfg_err;
        end
      end
      ST_DATA: begin
        if (w_fire) begin
          addr_next = ADDR_W'(next_beat_addr(AXI_ADDR_MAX_W'(addr_q), size_q,
                                             8'(len_q), burst_q));
          beat_next = beat_q + LEN_W'(1);
          dec_next  = dec_q | oor;
          slv_next  = slv_q | proto_err;
          if (last_beat) begin
            state_next = ST_RESP;
            bid_next   = id_q;
            bresp_next = dec_next ? RESP_DECERR :
                         slv_next ? RESP_SLVERR : RESP_OKAY;
          end
        end
      end
      ST_RESP: begin
        if (b_fire) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State, context and registered channel outputs.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      size_q  <= '0;
      burst_q <= BURST_FIXED;
      dec_q   <= 1'b0;
      slv_q   <= 1'b0;
      nowr_q  <= 1'b0;
      AWREADY <= 1'b0;
      WREADY  <= 1'b0;
      BVALID  <= 1'b0;
      BID     <= '0;
      BRESP   <= '0;
    end else begin
      state_q <= state_next;
      id_q    <= id_next;
      addr_q  <= addr_next;
      len_q   <= len_next;
      beat_q  <= beat_next;
      size_q  <= size_next;
      burst_q <= burst_next;
      dec_q   <= dec_next;
      slv_q   <= slv_next;
      nowr_q  <= nowr_next;
      AWREADY <= (state_next == ST_IDLE);
      WREADY  <= (state_next == ST_DATA);
      BVALID  <= (state_next == ST_RESP);
      BID     <= bid_next;
      BRESP   <= bresp_next;
    end
  end

  axi3_bytemem #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (MEM_WORDS_LOG2)
  ) u_mem (
    .clk     (ACLK),
    .we      (mem_we),
    .waddr   (addr_q[OFF_W +: MEM_WORDS_LOG2]),
    .wstrb   (WSTRB),
    .wdata   (WDATA),
    .raddr   (dbg_addr),
    .rdata_c (dbg_rdata)
  );

endmodule

// File: tb/tb_axi3_slave_write_sink.sv
// Self-checking bench for axi3_slave_write_sink: scoreboard queues of expected
// B responses and RAM words, filled as bursts are driven and drained as the
// DUT responds.
module tb_axi3_slave_write_sink;

  localparam int unsigned DATA_W         = 32;
  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned ID_W           = 3;
  localparam int unsigned LEN_W          = 4;
  localparam int unsigned BRST_W         = 3;
  localparam int unsigned MEM_WORDS_LOG2 = 10;
  localparam int unsigned TMO            = 50;

  logic                      ACLK = 1'b0;
  logic                      ARESETn;
  logic                      AWVALID, AWREADY;
  logic [ID_W-1:0]           AWID;
  logic [ADDR_W-1:0]         AWADDR;
  logic [LEN_W-1:0]          AWLEN;
  logic [2:0]                AWSIZE;
  logic [BRST_W-1:0]         AWBURST;
  logic                      WVALID, WREADY;
  logic [ID_W-1:0]           WID;
  logic [DATA_W-1:0]         WDATA;
  logic [DATA_W/8-1:0]       WSTRB;
  logic                      WLAST;
  logic                      BVALID, BREADY;
  logic [ID_W-1:0]           BID;
  logic [1:0]                BRESP;
  logic [MEM_WORDS_LOG2-1:0] dbg_addr;
  logic [DATA_W-1:0]         dbg_rdata;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } b_exp_t;

  typedef struct packed {
    logic [MEM_WORDS_LOG2-1:0] word;
    logic [DATA_W-1:0]         data;
  } m_exp_t;

  b_exp_t b_q[$];
  m_exp_t m_q[$];
  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0]   bd [16];
  logic [DATA_W/8-1:0] bs [16];

  always #5 ACLK = ~ACLK;

  axi3_slave_write_sink #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .LEN_W(LEN_W),
    .BRST_W(BRST_W), .MEM_WORDS_LOG2(MEM_WORDS_LOG2)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWID(AWID), .AWADDR(AWADDR),
    .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .WVALID(WVALID), .WREADY(WREADY), .WID(WID), .WDATA(WDATA),
    .WSTRB(WSTRB), .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY), .BID(BID), .BRESP(BRESP),
    .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata)
  );

  task automatic aw_send(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                         input logic [LEN_W-1:0] len, input logic [2:0] size,
                         input logic [BRST_W-1:0] bt);
    int n = 0;
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = bt;
    AWVALID = 1'b1;
    while (AWREADY !== 1'b1 && n < TMO) begin @(negedge ACLK); n++; end
    checks++;
    if (AWREADY !== 1'b1) begin
      errors++; $display("FAIL aw_timeout: AWREADY=%b required 1", AWREADY);
    end
    @(negedge ACLK);
    AWVALID = 1'b0;
    checks++;
    if (WREADY !== 1'b1) begin
      errors++; $display("FAIL wready_latency: WREADY=%b required 1", WREADY);
    end
  endtask

  task automatic w_send(input logic [DATA_W-1:0] d, input logic [DATA_W/8-1:0] s,
                        input bit last, input logic [ID_W-1:0] wid);
    int n = 0;
    WDATA = d; WSTRB = s; WLAST = last; WID = wid; WVALID = 1'b1;
    while (WREADY !== 1'b1 && n < TMO) begin @(negedge ACLK); n++; end
    checks++;
    if (WREADY !== 1'b1) begin
      errors++; $display("FAIL w_timeout: WREADY=%b required 1", WREADY);
    end
    @(negedge ACLK);
    WVALID = 1'b0; WLAST = 1'b0;
  endtask

  // Called right after the last beat: BVALID must already be up.
  task automatic b_recv(input int hold, input bit poke);
    b_exp_t e;
    int n = 0;
    if (b_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL b_scoreboard: queue empty, required an entry");
      return;
    end
    e = b_q.pop_front();
    checks++;
    if (BVALID !== 1'b1) begin
      errors++; $display("FAIL bvalid_latency: BVALID=%b required 1", BVALID);
    end
    for (int i = 0; i < hold; i++) begin
      BREADY = 1'b0;
      AWVALID = poke && (i % 2 == 0);
      AWID = 3'd7; AWADDR = 32'h300; AWLEN = '0; AWSIZE = 3'd2; AWBURST = 3'd1;
      @(negedge ACLK);
      checks++;
      if (BVALID !== 1'b1 || BID !== e.id || BRESP !== e.resp) begin
        errors++;
        $display("FAIL b_hold: BVALID=%b BID=%0d BRESP=%0d required 1/%0d/%0d",
                 BVALID, BID, BRESP, e.id, e.resp);
      end
      if (poke) begin
        checks++;
        if (AWREADY !== 1'b0) begin
          errors++; $display("FAIL aw_during_resp: AWREADY=%b required 0", AWREADY);
        end
      end
    end
    AWVALID = 1'b0;
    BREADY = 1'b1;
    while (BVALID !== 1'b1 && n < TMO) begin @(negedge ACLK); n++; end
    checks++;
    if (BVALID !== 1'b1 || BID !== e.id || BRESP !== e.resp) begin
      errors++;
      $display("FAIL b_resp: BVALID=%b BID=%0d BRESP=%0d required 1/%0d/%0d",
               BVALID, BID, BRESP, e.id, e.resp);
    end
    @(negedge ACLK);
    BREADY = 1'b0;
    checks++;
    if (BVALID !== 1'b0) begin
      errors++; $display("FAIL b_drop: BVALID=%b required 0", BVALID);
    end
  endtask

  task automatic mem_check();
    m_exp_t m;
    while (m_q.size() != 0) begin
      m = m_q.pop_front();
      dbg_addr = m.word;
      #1;
      checks++;
      if (dbg_rdata !== m.data) begin
        errors++;
        $display("FAIL mem_word[%0d]: got 0x%08h required 0x%08h", m.word, dbg_rdata, m.data);
      end
    end
  endtask

  task automatic do_burst(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                          input logic [LEN_W-1:0] len, input logic [2:0] size,
                          input logic [BRST_W-1:0] bt, input int nbeats,
                          input int last_at, input int bad_wid_at,
                          input int hold, input bit poke);
    aw_send(id, addr, len, size, bt);
    for (int i = 0; i < nbeats; i++)
      w_send(bd[i], bs[i], (i == last_at), (i == bad_wid_at) ? (id ^ ID_W'(1)) : id);
    b_recv(hold, poke);
    mem_check();
  endtask

  function automatic m_exp_t mw(input int word, input logic [DATA_W-1:0] data);
    mw.word = MEM_WORDS_LOG2'(word);
    mw.data = data;
  endfunction

  function automatic b_exp_t be(input int id, input int resp);
    be.id = ID_W'(id);
    be.resp = 2'(resp);
  endfunction

  task automatic test_reset();
    ARESETn = 1'b0;
    repeat (3) @(negedge ACLK);
    checks++;
    if (AWREADY !== 1'b0 || WREADY !== 1'b0 || BVALID !== 1'b0 ||
        BID !== '0 || BRESP !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: AW=%b W=%b BV=%b BID=%0d BRESP=%0d required 0/0/0/0/0",
               AWREADY, WREADY, BVALID, BID, BRESP);
    end
    ARESETn = 1'b1;
    @(negedge ACLK);
    checks++;
    if (AWREADY !== 1'b1) begin
      errors++; $display("FAIL reset_release: AWREADY=%b required 1", AWREADY);
    end
  endtask

  task automatic test_incr();
    for (int i = 0; i < 4; i++) begin bd[i] = DATA_W'(32'hA0 + i); bs[i] = 4'hF; end
    b_q.push_back(be(5, 0));
    for (int i = 0; i < 4; i++) m_q.push_back(mw(4 + i, DATA_W'(32'hA0 + i)));
    do_burst(3'd5, 32'h10, 4'd3, 3'd2, 3'd1, 4, 3, -1, 0, 1'b0);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 4; i++) begin bd[i] = DATA_W'(32'hB0 + i); bs[i] = 4'hF; end
    b_q.push_back(be(2, 0));
    m_q.push_back(mw(6, 32'hB0)); m_q.push_back(mw(7, 32'hB1));
    m_q.push_back(mw(4, 32'hB2)); m_q.push_back(mw(5, 32'hB3));
    do_burst(3'd2, 32'h18, 4'd3, 3'd2, 3'd2, 4, 3, -1, 0, 1'b0);
  endtask

  task automatic test_fixed();
    bd[0] = 32'h0; bs[0] = 4'hF;
    b_q.push_back(be(1, 0));
    do_burst(3'd1, 32'h0, 4'd0, 3'd2, 3'd1, 1, 0, -1, 0, 1'b0);
    bd[0] = 32'h11111111; bs[0] = 4'h1;
    bd[1] = 32'h22222222; bs[1] = 4'h2;
    bd[2] = 32'h33333333; bs[2] = 4'h4;
    b_q.push_back(be(3, 0));
    m_q.push_back(mw(0, 32'h00332211));
    do_burst(3'd3, 32'h0, 4'd2, 3'd2, 3'd0, 3, 2, -1, 0, 1'b0);
  endtask

  task automatic test_errors();
    // Out of range single beat: DECERR, word 0 (aliased index) untouched.
    bd[0] = 32'hDEADBEEF; bs[0] = 4'hF;
    b_q.push_back(be(4, 3));
    m_q.push_back(mw(0, 32'h00332211));
    do_burst(3'd4, 32'h1000, 4'd0, 3'd2, 3'd1, 1, 0, -1, 0, 1'b0);
    // Crossing the top: first beat lands, second is decode error.
    bd[0] = 32'h0000F00D; bd[1] = 32'h0000BAD0; bs[0] = 4'hF; bs[1] = 4'hF;
    b_q.push_back(be(6, 3));
    m_q.push_back(mw(1023, 32'h0000F00D)); m_q.push_back(mw(0, 32'h00332211));
    do_burst(3'd6, 32'hFFC, 4'd1, 3'd2, 3'd1, 2, 1, -1, 0, 1'b0);
    // Early WLAST on beat 2 of 4.
    for (int i = 0; i < 4; i++) begin bd[i] = DATA_W'(32'hC0 + i); bs[i] = 4'hF; end
    b_q.push_back(be(1, 2));
    m_q.push_back(mw(16, 32'hC0)); m_q.push_back(mw(17, 32'hC1));
    do_burst(3'd1, 32'h40, 4'd3, 3'd2, 3'd1, 2, 1, -1, 0, 1'b0);
    checks++;
    if (AWREADY !== 1'b1) begin
      errors++; $display("FAIL idle_after_early_last: AWREADY=%b required 1", AWREADY);
    end
    // WID mismatch on the second beat: still written.
    bd[0] = 32'hE0; bd[1] = 32'hE1;
    b_q.push_back(be(2, 2));
    m_q.push_back(mw(32, 32'hE0)); m_q.push_back(mw(33, 32'hE1));
    do_burst(3'd2, 32'h80, 4'd1, 3'd2, 3'd1, 2, 1, 1, 0, 1'b0);
    // WLAST never asserted: ends on beat len+1, still written.
    bd[0] = 32'hF0; bd[1] = 32'hF1;
    b_q.push_back(be(3, 2));
    m_q.push_back(mw(36, 32'hF0)); m_q.push_back(mw(37, 32'hF1));
    do_burst(3'd3, 32'h90, 4'd1, 3'd2, 3'd1, 2, -1, -1, 0, 1'b0);
    // Reserved burst type: SLVERR without writing.
    bd[0] = 32'h5555AAAA;
    b_q.push_back(be(0, 0));
    do_burst(3'd0, 32'hA0, 4'd0, 3'd2, 3'd1, 1, 0, -1, 0, 1'b0);
    bd[0] = 32'hFFFFFFFF;
    b_q.push_back(be(7, 2));
    m_q.push_back(mw(40, 32'h5555AAAA));
    do_burst(3'd7, 32'hA0, 4'd0, 3'd2, 3'd3, 1, 0, -1, 0, 1'b0);
    // WRAP with length 3 beats: SLVERR without writing.
    bd[0] = 32'h1; bd[1] = 32'h2; bd[2] = 32'h3;
    b_q.push_back(be(5, 2));
    m_q.push_back(mw(40, 32'h5555AAAA));
    do_burst(3'd5, 32'hA0, 4'd2, 3'd2, 3'd2, 3, 2, -1, 0, 1'b0);
    // Zero strobe beat is consumed silently.
    bd[0] = 32'h0; bs[0] = 4'h0; bd[1] = 32'h77; bs[1] = 4'hF;
    b_q.push_back(be(6, 0));
    m_q.push_back(mw(40, 32'h5555AAAA)); m_q.push_back(mw(41, 32'h77));
    do_burst(3'd6, 32'hA0, 4'd1, 3'd2, 3'd1, 2, 1, -1, 0, 1'b0);
    bs[0] = 4'hF;
  endtask

  task automatic test_b_hold();
    bd[0] = 32'h33333333; bs[0] = 4'hF;
    b_q.push_back(be(3, 0));
    m_q.push_back(mw(12, 32'h33333333));
    do_burst(3'd3, 32'h30, 4'd0, 3'd2, 3'd1, 1, 0, -1, 5, 1'b1);
    bd[0] = 32'h44444444;
    b_q.push_back(be(4, 0));
    m_q.push_back(mw(13, 32'h44444444)); m_q.push_back(mw(12, 32'h33333333));
    do_burst(3'd4, 32'h34, 4'd0, 3'd2, 3'd1, 1, 0, -1, 0, 1'b0);
  endtask

  task automatic test_reset_mid_burst();
    aw_send(3'd6, 32'h100, 4'd7, 3'd2, 3'd1);
    w_send(32'hD0, 4'hF, 1'b0, 3'd6);
    WDATA = 32'hD1; WSTRB = 4'hF; WID = 3'd6; WLAST = 1'b0; WVALID = 1'b1;
    ARESETn = 1'b0;
    @(negedge ACLK);
    checks++;
    if (AWREADY !== 1'b0 || WREADY !== 1'b0 || BVALID !== 1'b0 ||
        BID !== '0 || BRESP !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid: AW=%b W=%b BV=%b BID=%0d BRESP=%0d required 0/0/0/0/0",
               AWREADY, WREADY, BVALID, BID, BRESP);
    end
    WVALID = 1'b0;
    ARESETn = 1'b1;
    @(negedge ACLK);
    checks++;
    if (AWREADY !== 1'b1 || BVALID !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_release: AWREADY=%b BVALID=%b required 1/0", AWREADY, BVALID);
    end
    m_q.push_back(mw(64, 32'hD0));
    mem_check();
    bd[0] = 32'h900D0001; bd[1] = 32'h900D0002; bs[0] = 4'hF; bs[1] = 4'hF;
    b_q.push_back(be(1, 0));
    m_q.push_back(mw(128, 32'h900D0001)); m_q.push_back(mw(129, 32'h900D0002));
    do_burst(3'd1, 32'h200, 4'd1, 3'd2, 3'd1, 2, 1, -1, 0, 1'b0);
  endtask

  initial begin
    ARESETn = 1'b0;
    AWVALID = 1'b0; AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0;
    WVALID = 1'b0; WID = '0; WDATA = '0; WSTRB = '0; WLAST = 1'b0;
    BREADY = 1'b0; dbg_addr = '0;
    @(negedge ACLK);
    test_reset();
    test_incr();
    test_wrap();
    test_fixed();
    test_errors();
    test_b_hold();
    test_reset_mid_burst();
    checks++;
    if (b_q.size() != 0) begin
      errors++; $display("FAIL b_leftover: %0d entries required 0", b_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
